// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : reg_bus_arbiter
// Purpose : Round-robin arbiter sharing one register port among NReq requesters.
// Revision: 1.0 - initial release
// ============================================================================
module reg_bus_arbiter #(
  parameter int NReq  = 2,
  parameter int RegAw = 8,
  parameter int RegDw = 32,
  localparam int RegBw = RegDw / 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [NReq-1:0]         req_i,
  input  logic [NReq-1:0]         req_we_i,
  input  logic [NReq*RegAw-1:0]   req_addr_i,
  input  logic [NReq*RegDw-1:0]   req_wdata_i,
  input  logic [NReq*RegBw-1:0]   req_be_i,
  output logic [NReq-1:0]         gnt_o,
  output logic [NReq-1:0]         rvalid_o,
  output logic [RegDw-1:0]        rdata_o,
  output logic                    error_o,
  output logic                    re_o,
  output logic                    we_o,
  output logic [RegAw-1:0]        addr_o,
  output logic [RegDw-1:0]        wdata_o,
  output logic [RegBw-1:0]        be_o,
  input  logic [RegDw-1:0]        rdata_i,
  input  logic                    error_i
);

  localparam int IdxW = $clog2(NReq);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IdxW-1:0]  ptr, idx, win, win_hi, win_lo;
  logic [NReq-1:0]  hi_mask, masked;
  logic             grant;
  logic             cmd_we;
  logic [RegAw-1:0] cmd_addr;
  logic [RegDw-1:0] cmd_wdata;
  logic [RegBw-1:0] cmd_be;
  logic [RegDw-1:0] rsp_data;
  logic             rsp_err;

  // Requests at or above the pointer take priority; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask = '0;
    win_hi  = '0;
    win_lo  = '0;
    for (int i = 0; i < NReq; i++) begin
      hi_mask[i] = (IdxW'(i) >= ptr);
    end
    masked = req_i & hi_mask;
    for (int i = NReq - 1; i >= 0; i--) begin
      if (masked[i]) win_hi = IdxW'(i);
      if (req_i[i])  win_lo = IdxW'(i);
    end
    win = (|masked) ? win_hi : win_lo;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if ((|req_i) && !PRESET) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: state_next = RESP;
      RESP: begin
        if ((|req_i) && !PRESET) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        idx       <= win;
        ptr       <= (win == IdxW'(NReq - 1)) ? '0 : win + 1'b1;
        cmd_we    <= req_we_i[win];
        cmd_addr  <= req_addr_i[win*RegAw +: RegAw];
        cmd_wdata <= req_wdata_i[win*RegDw +: RegDw];
        cmd_be    <= req_be_i[win*RegBw +: RegBw];
      end
      if (state == ACCESS) begin
        rsp_data <= cmd_we ? '0 : rdata_i;
        rsp_err  <= error_i;
      end
    end
  end

  assign gnt_o    = grant ? (NReq'(1) << win) : '0;
  assign rvalid_o = (state == RESP) ? (NReq'(1) << idx) : '0;
  assign re_o     = (state == ACCESS) && !cmd_we;
  assign we_o     = (state == ACCESS) && cmd_we;
  assign addr_o   = cmd_addr;
  assign wdata_o  = cmd_wdata;
  assign be_o     = cmd_be;
  assign rdata_o  = rsp_data;
  assign error_o  = rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// Testbench for reg_bus_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_reg_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic [N-1:0]    req_i = '0, req_we_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_wdata_i = '0;
  logic [N*BW-1:0] req_be_i = '0;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o, wdata_o;
  logic            error_o, re_o, we_o;
  logic [AW-1:0]   addr_o;
  logic [BW-1:0]   be_o;
  logic [DW-1:0]   rdata_i = '0;
  logic            error_i = 1'b0;

  reg_bus_arbiter #(.NReq(N), .RegAw(AW), .RegDw(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .error_o(error_o),
    .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rdata_i(rdata_i), .error_i(error_i)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [15:0] a,
                       input logic [63:0] wd, input logic [7:0] be,
                       input logic [31:0] rd, input logic e);
    @(negedge PCLK);
    req_i = r; req_we_i = w; req_addr_i = a; req_wdata_i = wd; req_be_i = be;
    rdata_i = rd; error_i = e;
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;   logic [1:0]  we;
    logic [7:0]  a0;    logic [7:0]  a1;
    logic [31:0] wd;    logic [31:0] rdi;  logic erri;
    logic [1:0]  egnt;  logic ere;  logic ewe;
    logic [7:0]  eaddr; logic [31:0] ewd;
    logic [1:0]  ervalid; logic [31:0] erdata; logic eerr;
  } vec_t;

  typedef struct {
    int who; logic we; logic [7:0] addr; logic [31:0] wdata; logic [3:0] be;
    logic [31:0] rdata; logic err; int gcyc;
  } txn_t;

  vec_t tv[15];
  txn_t q[$];

  initial begin
    // single read, write with error, contention, then drain
    tv[0]  = '{2'b01, 2'b00, 8'h10, 8'h00, 32'h0,        32'h0,        1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[1]  = '{2'b00, 2'b00, 8'h20, 8'h00, 32'h0,        32'hDEADBEEF, 1'b0, 2'b00, 1'b1, 1'b0, 8'h10, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[2]  = '{2'b00, 2'b00, 8'h20, 8'h00, 32'h0,        32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 32'hDEADBEEF, 1'b0};
    tv[3]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[4]  = '{2'b10, 2'b10, 8'h00, 8'h04, 32'h12345678, 32'h0,        1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[5]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'hAAAA5555, 1'b1, 2'b00, 1'b0, 1'b1, 8'h04, 32'h12345678, 2'b00, 32'h0,        1'b0};
    tv[6]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0,        2'b10, 32'h0,        1'b1};
    tv[7]  = '{2'b11, 2'b00, 8'h30, 8'h31, 32'h0,        32'h0,        1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[8]  = '{2'b11, 2'b00, 8'h30, 8'h31, 32'h0,        32'h11111111, 1'b0, 2'b00, 1'b1, 1'b0, 8'h30, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[9]  = '{2'b11, 2'b00, 8'h30, 8'h31, 32'h0,        32'h0,        1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 32'h11111111, 1'b0};
    tv[10] = '{2'b11, 2'b00, 8'h30, 8'h31, 32'h0,        32'h22222222, 1'b1, 2'b00, 1'b1, 1'b0, 8'h31, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[11] = '{2'b11, 2'b00, 8'h30, 8'h31, 32'h0,        32'h0,        1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 32'h0,        2'b10, 32'h22222222, 1'b1};
    tv[12] = '{2'b00, 2'b00, 8'h30, 8'h31, 32'h0,        32'h33333333, 1'b0, 2'b00, 1'b1, 1'b0, 8'h30, 32'h0,        2'b00, 32'h0,        1'b0};
    tv[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 32'h33333333, 1'b0};
    tv[14] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 32'h0,        1'b0};

    // Reset state
    @(negedge PCLK); #1;
    chk("rst_gnt", gnt_o, 0);   chk("rst_rvalid", rvalid_o, 0);
    chk("rst_re", re_o, 0);     chk("rst_we", we_o, 0);
    chk("rst_addr", addr_o, 0); chk("rst_wdata", wdata_o, 0);
    chk("rst_be", be_o, 0);     chk("rst_rdata", rdata_o, 0);
    chk("rst_error", error_o, 0);
    PRESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].req, tv[i].we, {tv[i].a1, tv[i].a0}, {tv[i].wd, tv[i].wd}, 8'hF3,
            tv[i].rdi, tv[i].erri);
      chk($sformatf("vec%0d_gnt", i), gnt_o, tv[i].egnt);
      chk($sformatf("vec%0d_re", i), re_o, tv[i].ere);
      chk($sformatf("vec%0d_we", i), we_o, tv[i].ewe);
      chk($sformatf("vec%0d_rvalid", i), rvalid_o, tv[i].ervalid);
      if (tv[i].ere || tv[i].ewe) begin
        chk($sformatf("vec%0d_addr", i), addr_o, tv[i].eaddr);
        chk($sformatf("vec%0d_wdata", i), wdata_o, tv[i].ewd);
      end
      if (tv[i].ervalid != 2'b00) begin
        chk($sformatf("vec%0d_rdata", i), rdata_o, tv[i].erdata);
        chk($sformatf("vec%0d_error", i), error_o, tv[i].eerr);
      end
    end

    // Withdrawal: requester 1 raises during ACCESS and drops before RESP
    drive(2'b01, 2'b00, 16'h0010, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("wd_gnt0", gnt_o, 2'b01);
    drive(2'b10, 2'b00, 16'h0010, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("wd_gnt_access", gnt_o, 2'b00); chk("wd_re", re_o, 1);
    drive(2'b00, 2'b00, 16'h0010, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("wd_gnt_resp", gnt_o, 2'b00);   chk("wd_rvalid", rvalid_o, 2'b01);
    drive(2'b00, 2'b00, 16'h0010, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("wd_no_strobe", {re_o, we_o}, 2'b00); chk("wd_no_rvalid", rvalid_o, 2'b00);
    drive(2'b10, 2'b00, 16'h0010, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("wd_idle_grant", gnt_o, 2'b10);
    drive(2'b00, 2'b00, 16'h0010, 64'h0, 8'hF3, 32'h0, 1'b0);
    drive(2'b00, 2'b00, 16'h0010, 64'h0, 8'hF3, 32'h0, 1'b0);

    // Reset during ACCESS of a write by requester 1
    drive(2'b10, 2'b10, 16'h0810, 64'h55, 8'hF3, 32'h0, 1'b0);
    chk("ro_gnt", gnt_o, 2'b10);
    drive(2'b00, 2'b00, 16'h0000, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("ro_we_before", we_o, 1);
    PRESET = 1'b1; #1;
    chk("ro_we_drop", we_o, 0);    chk("ro_re_drop", re_o, 0);
    chk("ro_addr_clr", addr_o, 0); chk("ro_rvalid", rvalid_o, 0);
    drive(2'b11, 2'b00, 16'h0000, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("ro_gnt_in_reset", gnt_o, 2'b00);
    req_i = '0; PRESET = 1'b0;
    drive(2'b00, 2'b00, 16'h0000, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("ro_no_rvalid", rvalid_o, 2'b00); chk("ro_no_strobe", {re_o, we_o}, 2'b00);
    drive(2'b11, 2'b00, 16'h0000, 64'h0, 8'hF3, 32'h0, 1'b0);
    chk("ro_first_gnt", gnt_o, 2'b01);
    drive(2'b00, 2'b00, 16'h0000, 64'h0, 8'hF3, 32'h0, 1'b0);
    drive(2'b00, 2'b00, 16'h0000, 64'h0, 8'hF3, 32'h0, 1'b0);

    // Randomized traffic against a transaction-level model
    @(negedge PCLK); PRESET = 1'b1; req_i = '0; #2; PRESET = 1'b0;
    begin
      int ptr, t, s, r, win;
      logic [1:0]  rq, rw;
      logic [15:0] ra;
      logic [63:0] rwd;
      logic [7:0]  rbe;
      logic [31:0] rrd;
      logic        rer;
      logic [1:0]  egnt;
      txn_t nt;
      ptr = 0;
      q.delete();
      for (t = 0; t < 600; t++) begin
        rq = 2'($urandom_range(0, 3)); rw = 2'($urandom_range(0, 3));
        ra = 16'($urandom); rwd = {$urandom, $urandom}; rbe = 8'($urandom);
        rrd = $urandom; rer = 1'($urandom_range(0, 1));
        drive(rq, rw, ra, rwd, rbe, rrd, rer);
        // An access granted at cycle g strobes at g+1 and responds at g+2.
        s = -1; r = -1;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].gcyc == t - 1) s = i;
          if (q[i].gcyc == t - 2) r = i;
        end
        egnt = 2'b00; win = -1;
        if (s < 0 && rq != 2'b00) begin
          for (int i = 0; i < N; i++) begin
            if (win < 0 && rq[(ptr + i) % N]) win = (ptr + i) % N;
          end
          egnt = 2'(1 << win);
        end
        chk("rnd_gnt", gnt_o, egnt);
        chk("rnd_re", re_o, (s >= 0) && !q[s >= 0 ? s : 0].we);
        chk("rnd_we", we_o, (s >= 0) && q[s >= 0 ? s : 0].we);
        chk("rnd_rvalid", rvalid_o, (r >= 0) ? 2'(1 << q[r].who) : 2'b00);
        if (s >= 0) begin
          chk("rnd_addr", addr_o, q[s].addr);
          chk("rnd_wdata", wdata_o, q[s].wdata);
          chk("rnd_be", be_o, q[s].be);
          q[s].rdata = q[s].we ? 32'h0 : rrd;
          q[s].err = rer;
        end
        if (r >= 0) begin
          chk("rnd_rdata", rdata_o, q[r].rdata);
          chk("rnd_error", error_o, q[r].err);
        end
        if (win >= 0) begin
          nt.who = win; nt.we = rw[win]; nt.addr = ra[win*8 +: 8];
          nt.wdata = rwd[win*32 +: 32]; nt.be = rbe[win*4 +: 4];
          nt.rdata = 32'h0; nt.err = 1'b0; nt.gcyc = t;
          q.push_back(nt);
          ptr = (win + 1) % N;
        end
        while (q.size() > 0 && q[0].gcyc <= t - 2) void'(q.pop_front());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
